// File: rtl/cgra_tile.sv
// cgra_tile: one CGRA mesh processing element: a 64-bit serial configuration scan chain plus a 48-bit operand-select/ALU datapath.
// Latency: 1 clk from operands/config to tile_output and send links; a scan bit reaches jtag_data_out 64 clks after entry.
// Backpressure: none; one ALU result per run-mode cycle. Neighbour links are plain registered wires with no handshake.
module cgra_tile #(
   parameter int unsigned tile_id = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           jtag_data_in,
   output logic           jtag_data_out,
   input  logic           program_mode,
   input  logic [383:0]   recv_from_tile_data,
   output logic [383:0]   send_to_tile_data,
   output logic [47:0]    tile_output
);

   // tile_id only tags the instance for mesh bookkeeping; it has no datapath effect.
   if (tile_id > 32'hFFFF_FFFE) begin : g_tile_id_tag
   end

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_MUL  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_ASR  = 4'd10,
      OP_MIN  = 4'd11,
      OP_MAX  = 4'd12,
      OP_EQ   = 4'd13,
      OP_LT   = 4'd14,
      OP_PASS = 4'd15
   } opcode_e;

   // Configuration word and result register.
   logic [63:0] cfg_q, cfg_d;
   logic [47:0] result_q, result_d;

   // Decoded configuration fields.
   opcode_e     opcode;
   logic [3:0]  src_a_sel;
   logic [3:0]  src_b_sel;
   logic [7:0]  route_en;
   logic [15:0] imm16;
   logic [47:0] imm_sx;

   assign opcode    = opcode_e'(cfg_q[3:0]);
   assign src_a_sel = cfg_q[7:4];
   assign src_b_sel = cfg_q[11:8];
   assign route_en  = cfg_q[19:12];
   assign imm16     = cfg_q[35:20];
   assign imm_sx    = {{32{imm16[15]}}, imm16};

   // Unpack the flat neighbour bus into per-direction links.
   logic [47:0] link_in [8];
   for (genvar d = 0; d < 8; d++) begin : g_link
      assign link_in[d] = recv_from_tile_data[48*d +: 48];
   end

   // Operand selection: links 0-7, sign-extended immediate, feedback, else zero.
   function automatic logic [47:0] pick_src(
      input logic [3:0]  sel,
      input logic [47:0] imm_v,
      input logic [47:0] fb_v,
      input logic [47:0] l0, input logic [47:0] l1,
      input logic [47:0] l2, input logic [47:0] l3,
      input logic [47:0] l4, input logic [47:0] l5,
      input logic [47:0] l6, input logic [47:0] l7
   );
      logic [47:0] v;
      v = '0;
      case (sel)
         4'd0:    v = l0;
         4'd1:    v = l1;
         4'd2:    v = l2;
         4'd3:    v = l3;
         4'd4:    v = l4;
         4'd5:    v = l5;
         4'd6:    v = l6;
         4'd7:    v = l7;
         4'd8:    v = imm_v;
         4'd9:    v = fb_v;
         default: v = '0;
      endcase
      return v;
   endfunction

   logic [47:0] opnd_a, opnd_b;

   // Operand muxes for both ALU inputs.
   always_comb begin
      opnd_a = pick_src(src_a_sel, imm_sx, result_q,
                        link_in[0], link_in[1], link_in[2], link_in[3],
                        link_in[4], link_in[5], link_in[6], link_in[7]);
      opnd_b = pick_src(src_b_sel, imm_sx, result_q,
                        link_in[0], link_in[1], link_in[2], link_in[3],
                        link_in[4], link_in[5], link_in[6], link_in[7]);
   end

   logic [47:0] alu_res;
   logic [5:0]  sh_amt;
   logic        sh_big;
   logic        a_lt_b;

   // 48-bit ALU; shift amounts of 48..63 saturate to zero (or sign fill for ASR).
   always_comb begin
      alu_res = result_q;
      sh_amt  = opnd_b[5:0];
      sh_big  = (sh_amt >= 6'd48);
      a_lt_b  = ($signed(opnd_a) < $signed(opnd_b));
      case (opcode)
         OP_NOP:  alu_res = result_q;
         OP_ADD:  alu_res = opnd_a + opnd_b;
         OP_SUB:  alu_res = opnd_a - opnd_b;
         OP_MUL:  alu_res = opnd_a * opnd_b;
         OP_AND:  alu_res = opnd_a & opnd_b;
         OP_OR:   alu_res = opnd_a | opnd_b;
         OP_XOR:  alu_res = opnd_a ^ opnd_b;
         OP_NOT:  alu_res = ~opnd_a;
         OP_SHL:  alu_res = sh_big ? 48'd0 : (opnd_a << sh_amt);
         OP_SHR:  alu_res = sh_big ? 48'd0 : (opnd_a >> sh_amt);
         OP_ASR:  alu_res = sh_big ? {48{opnd_a[47]}}
                                   : 48'($signed(opnd_a) >>> sh_amt);
         OP_MIN:  alu_res = a_lt_b ? opnd_a : opnd_b;
         OP_MAX:  alu_res = a_lt_b ? opnd_b : opnd_a;
         OP_EQ:   alu_res = {47'd0, (opnd_a == opnd_b)};
         OP_LT:   alu_res = {47'd0, a_lt_b};
         OP_PASS: alu_res = opnd_a;
         default: alu_res = result_q;
      endcase
   end

   // Next state: shift config and clear result while programming, else execute.
   always_comb begin
      cfg_d    = cfg_q;
      result_d = alu_res;
      if (program_mode) begin
         cfg_d    = {jtag_data_in, cfg_q[63:1]};
         result_d = '0;
      end
   end

   // State registers; async reset discards any partial configuration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_q    <= '0;
         result_q <= '0;
      end else begin
         cfg_q    <= cfg_d;
         result_q <= result_d;
      end
   end

   assign jtag_data_out = cfg_q[0];
   assign tile_output   = result_q;

   // Route the result onto enabled outgoing links; all links idle while programming.
   always_comb begin
      send_to_tile_data = '0;
      for (int d = 0; d < 8; d++) begin
         if (route_en[d] && !program_mode) begin
            send_to_tile_data[48*d +: 48] = result_q;
         end
      end
   end

endmodule

// File: tb/tb_cgra_tile.sv
// tb_cgra_tile: self-checking bench for cgra_tile against a behavioural model.
// Latency: checks tile_output/send one clock after operands; scan output 64 clocks after entry.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_cgra_tile;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         jtag_data_in = 1'b0;
   logic         jtag_data_out;
   logic         program_mode = 1'b0;
   logic [383:0] recv = '0;
   logic [383:0] send;
   logic [47:0]  tile_output;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] m_cfg = '0;
   logic [47:0] m_res = '0;

   cgra_tile #(.tile_id(3)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .jtag_data_in        (jtag_data_in),
      .jtag_data_out       (jtag_data_out),
      .program_mode        (program_mode),
      .recv_from_tile_data (recv),
      .send_to_tile_data   (send),
      .tile_output         (tile_output)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mk_cfg(input int op, input int sa, input int sb,
                                          input logic [7:0] route, input logic [15:0] imm);
      logic [63:0] w;
      w = '0;
      w[3:0]   = op[3:0];
      w[7:4]   = sa[3:0];
      w[11:8]  = sb[3:0];
      w[19:12] = route;
      w[35:20] = imm;
      return w;
   endfunction

   function automatic longint sx(input logic [47:0] a);
      return a[47] ? longint'({16'hFFFF, a}) : longint'({16'h0000, a});
   endfunction

   function automatic logic [47:0] m_src(input int sel);
      logic [15:0] imm;
      imm = m_cfg[35:20];
      if (sel < 8) return recv[sel*48 +: 48];
      if (sel == 8) return imm[15] ? {32'hFFFF_FFFF, imm} : {32'h0, imm};
      if (sel == 9) return m_res;
      return 48'd0;
   endfunction

   function automatic logic [47:0] m_alu(input int op, input logic [47:0] a,
                                         input logic [47:0] b, input logic [47:0] r);
      logic [63:0] t;
      logic [95:0] p;
      longint      s;
      int          amt;
      amt = int'(b[5:0]);
      case (op)
         0:  return r;
         1:  begin t = {16'h0, a} + {16'h0, b}; return t[47:0]; end
         2:  begin t = {16'h0, a} - {16'h0, b}; return t[47:0]; end
         3:  begin p = {48'h0, a} * {48'h0, b}; return p[47:0]; end
         4:  return a & b;
         5:  return a | b;
         6:  return a ^ b;
         7:  return ~a;
         8:  begin if (amt >= 48) return 48'd0; t = {16'h0, a} << amt; return t[47:0]; end
         9:  begin if (amt >= 48) return 48'd0; t = {16'h0, a} >> amt; return t[47:0]; end
         10: begin s = sx(a) >>> amt; return s[47:0]; end
         11: return (sx(a) < sx(b)) ? a : b;
         12: return (sx(a) > sx(b)) ? a : b;
         13: return (a == b) ? 48'd1 : 48'd0;
         14: return (sx(a) < sx(b)) ? 48'd1 : 48'd0;
         default: return a;
      endcase
   endfunction

   function automatic logic [383:0] m_send(input logic [7:0] route, input logic [47:0] r);
      logic [383:0] s;
      s = '0;
      for (int d = 0; d < 8; d++) if (route[d]) s[d*48 +: 48] = r;
      return s;
   endfunction

   function automatic logic [383:0] rand_links();
      logic [383:0] l;
      for (int d = 0; d < 8; d++) l[d*48 +: 48] = {$urandom(), $urandom()} & 64'h0000_FFFF_FFFF_FFFF;
      return l;
   endfunction

   // Shift a full word LSB first; programming clears the result.
   task automatic shift_word(input logic [63:0] w);
      program_mode = 1'b1;
      for (int i = 0; i < 64; i++) begin
         jtag_data_in = w[i];
         tick();
      end
      program_mode = 1'b0;
      jtag_data_in = 1'b0;
      m_cfg = w;
      m_res = '0;
   endtask

   // One run-mode clock with the model advanced alongside.
   task automatic run_step();
      logic [47:0] nxt;
      nxt = m_alu(int'(m_cfg[3:0]), m_src(int'(m_cfg[7:4])), m_src(int'(m_cfg[11:8])), m_res);
      tick();
      m_res = nxt;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      n_cmp++; if (tile_output !== 48'd0) begin n_err++; $display("FAIL reset_out: got %0h want 0", tile_output); end
      n_cmp++; if (send !== 384'd0) begin n_err++; $display("FAIL reset_send: got %0h want 0", send); end
      n_cmp++; if (jtag_data_out !== 1'b0) begin n_err++; $display("FAIL reset_jtag: got %0b want 0", jtag_data_out); end
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_scan_chain();
      logic [63:0] words [4];
      words[0] = 64'h0;
      words[1] = 64'hFFFF_0000_0000_0001;
      words[2] = {$urandom(), $urandom()};
      words[3] = {$urandom(), $urandom()};
      program_mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 64; i++) begin
            jtag_data_in = words[k][i];
            if (k > 0) begin
               n_cmp++;
               if (jtag_data_out !== words[k-1][i]) begin
                  n_err++; $display("FAIL scan_bit w%0d b%0d: got %0b want %0b", k, i, jtag_data_out, words[k-1][i]);
               end
            end
            if (k == 1 && i == 5) begin
               n_cmp++; if (send !== 384'd0) begin n_err++; $display("FAIL scan_send: got %0h want 0", send); end
            end
            tick();
         end
      end
      n_cmp++; if (jtag_data_out !== words[3][0]) begin n_err++; $display("FAIL scan_final: got %0b want %0b", jtag_data_out, words[3][0]); end
      program_mode = 1'b0;
      jtag_data_in = 1'b0;
      m_cfg = words[3];
      m_res = '0;
   endtask

   task automatic test_add_link();
      shift_word(mk_cfg(1, 0, 8, 8'h01, 16'h0005));
      recv = '0;
      recv[47:0] = 48'd10;
      recv[95:48] = 48'd777;
      run_step();
      n_cmp++; if (tile_output !== 48'd15) begin n_err++; $display("FAIL add_out: got %0h want f", tile_output); end
      n_cmp++; if (send !== {336'd0, 48'd15}) begin n_err++; $display("FAIL add_send: got %0h want f in slot0", send); end
      program_mode = 1'b1;
      #1;
      n_cmp++; if (send !== 384'd0) begin n_err++; $display("FAIL prog_send_gate: got %0h want 0", send); end
      n_cmp++; if (tile_output !== 48'd15) begin n_err++; $display("FAIL prog_hold: got %0h want f", tile_output); end
      tick();
      n_cmp++; if (tile_output !== 48'd0) begin n_err++; $display("FAIL prog_clear: got %0h want 0", tile_output); end
      program_mode = 1'b0;
   endtask

   task automatic test_counter();
      logic [47:0] e;
      shift_word(mk_cfg(1, 9, 8, 8'h00, 16'h0001));
      for (int k = 1; k <= 4; k++) begin
         recv = rand_links();
         tick();
         n_cmp++; if (tile_output !== 48'(k)) begin n_err++; $display("FAIL count_up%0d: got %0h want %0h", k, tile_output, k); end
      end
      shift_word(mk_cfg(1, 9, 8, 8'h80, 16'hFFFF));
      e = '0;
      for (int k = 1; k <= 3; k++) begin
         e = e - 48'd1;
         tick();
         n_cmp++; if (tile_output !== e) begin n_err++; $display("FAIL count_dn%0d: got %0h want %0h", k, tile_output, e); end
      end
      n_cmp++; if (send[383:336] !== 48'hFFFF_FFFF_FFFD) begin n_err++; $display("FAIL count_send7: got %0h want fffffffffffd", send[383:336]); end
   endtask

   task automatic test_shift_edges();
      recv = '0;
      recv[3*48 +: 48] = 48'h8000_0000_0000;
      shift_word(mk_cfg(9, 3, 8, 8'h00, 16'd47));
      tick();
      n_cmp++; if (tile_output !== 48'd1) begin n_err++; $display("FAIL shr47: got %0h want 1", tile_output); end
      shift_word(mk_cfg(9, 3, 8, 8'h00, 16'd48));
      tick();
      n_cmp++; if (tile_output !== 48'd0) begin n_err++; $display("FAIL shr48: got %0h want 0", tile_output); end
      shift_word(mk_cfg(10, 3, 8, 8'h00, 16'd48));
      tick();
      n_cmp++; if (tile_output !== 48'hFFFF_FFFF_FFFF) begin n_err++; $display("FAIL asr48: got %0h want ffffffffffff", tile_output); end
      shift_word(mk_cfg(10, 3, 8, 8'h00, 16'd4));
      tick();
      n_cmp++; if (tile_output !== 48'hF800_0000_0000) begin n_err++; $display("FAIL asr4: got %0h want f80000000000", tile_output); end
      recv[3*48 +: 48] = 48'd1;
      shift_word(mk_cfg(8, 3, 8, 8'h00, 16'd63));
      tick();
      n_cmp++; if (tile_output !== 48'd0) begin n_err++; $display("FAIL shl63: got %0h want 0", tile_output); end
   endtask

   task automatic test_lt_mul();
      shift_word(mk_cfg(14, 8, 10, 8'h00, 16'hFFFF));
      tick();
      n_cmp++; if (tile_output !== 48'd1) begin n_err++; $display("FAIL lt_neg: got %0h want 1", tile_output); end
      recv = '0;
      recv[47:0]  = 48'h1_0000_0000;
      recv[95:48] = 48'h1_0000_0000;
      shift_word(mk_cfg(3, 0, 1, 8'h00, 16'h0));
      tick();
      n_cmp++; if (tile_output !== 48'd0) begin n_err++; $display("FAIL mul_trunc: got %0h want 0", tile_output); end
   endtask

   task automatic test_random();
      logic [7:0] route;
      for (int t = 0; t < 24; t++) begin
         route = 8'($urandom());
         shift_word(mk_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                           route, 16'($urandom())));
         n_cmp++; if (jtag_data_out !== m_cfg[0]) begin n_err++; $display("FAIL rnd_jtag t%0d: got %0b want %0b", t, jtag_data_out, m_cfg[0]); end
         for (int s = 0; s < 6; s++) begin
            recv = rand_links();
            if (s == 2) recv[$urandom_range(0, 7)*48 +: 48] = 48'($urandom_range(0, 63));
            run_step();
            n_cmp++;
            if (tile_output !== m_res) begin
               n_err++; $display("FAIL rnd_out t%0d s%0d op%0d: got %0h want %0h", t, s, m_cfg[3:0], tile_output, m_res);
            end
            n_cmp++;
            if (send !== m_send(route, m_res)) begin
               n_err++; $display("FAIL rnd_send t%0d s%0d: got %0h want %0h", t, s, send, m_send(route, m_res));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] w;
      w = mk_cfg(1, 9, 8, 8'hFF, 16'h0001);
      shift_word(w);
      for (int k = 0; k < 3; k++) tick();
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (tile_output !== 48'd0) begin n_err++; $display("FAIL rstrun_out: got %0h want 0", tile_output); end
      n_cmp++; if (send !== 384'd0) begin n_err++; $display("FAIL rstrun_send: got %0h want 0", send); end
      n_cmp++; if (jtag_data_out !== 1'b0) begin n_err++; $display("FAIL rstrun_jtag: got %0b want 0", jtag_data_out); end
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         recv = rand_links();
         tick();
         n_cmp++; if (tile_output !== 48'd0 || send !== 384'd0) begin n_err++; $display("FAIL rstrun_idle%0d: got %0h want 0", k, tile_output); end
      end
      program_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         jtag_data_in = w[i];
         tick();
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (jtag_data_out !== 1'b0 || tile_output !== 48'd0) begin n_err++; $display("FAIL rstshift: got %0b/%0h want 0/0", jtag_data_out, tile_output); end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 24; i++) begin
         jtag_data_in = w[i];
         tick();
      end
      program_mode = 1'b0;
      for (int k = 0; k < 3; k++) begin
         recv = rand_links();
         tick();
         n_cmp++; if (tile_output !== 48'd0 || send !== 384'd0) begin n_err++; $display("FAIL partial_idle%0d: got %0h want 0", k, tile_output); end
      end
      shift_word(w);
      tick();
      tick();
      n_cmp++; if (tile_output !== 48'd2) begin n_err++; $display("FAIL reprog_out: got %0h want 2", tile_output); end
      n_cmp++; if (send !== {8{48'd2}}) begin n_err++; $display("FAIL reprog_send: got %0h want 2 in all slots", send); end
   endtask

   initial begin
      test_reset();
      test_scan_chain();
      test_add_link();
      test_counter();
      test_shift_edges();
      test_lt_mul();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cgra_tile.md
Name: cgra_tile

Overview:
- One processing element of the CGRA mesh.
- A 64-bit configuration word is loaded serially through a JTAG-style scan chain while program_mode is high. The chain is daisy-chainable through jtag_data_out.
- In run mode the tile selects two 48-bit operands from its 8 neighbour links, an immediate, or its own result. It computes one ALU operation per cycle and drives the registered result to tile_output and to the enabled neighbour links.

Parameters:
- tile_id, 0, tile identifier for mesh instantiation and debug; no functional effect in this version.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- jtag_data_in  input  1  serial configuration bit, LSB of word first.
- jtag_data_out  output  1  serial chain output; feeds the next tile's jtag_data_in.
- program_mode  input  1  1 = shift configuration, 0 = execute.
- recv_from_tile_data  input  384  8 neighbour links; link d = bits [48d+47:48d].
- send_to_tile_data  output  384  8 outgoing links, same slot layout.
- tile_output  output  48  current result register.

Behaviour:
- Reset (rst=0, asynchronous): cfg[63:0]=0, result=0. All outputs read 0: send_to_tile_data=0, tile_output=0, jtag_data_out=0.
- Config shift: on each rising clk with program_mode=1, cfg <= {jtag_data_in, cfg[63:1]}.
  - After exactly 64 shifts, the first bit presented sits in cfg[0].
  - jtag_data_out = cfg[0] (combinational), so a bit reappears on jtag_data_out 64 clocks after entry.
- While program_mode=1: result is synchronously cleared to 0 and send_to_tile_data=0. cfg is frozen whenever program_mode=0.
- Config fields:
  - cfg[3:0] opcode.
  - cfg[7:4] src_a select.
  - cfg[11:8] src_b select.
  - cfg[19:12] route_en, one bit per outgoing link d.
  - cfg[35:20] imm16.
  - cfg[63:36] reserved; stored and shifted, otherwise ignored.
- Source select encoding:
  - 0-7 = recv_from_tile_data link 0-7.
  - 8 = imm16 sign-extended to 48 bits.
  - 9 = result (feedback).
  - 10-15 = 48'd0.
- Execute: on each rising clk with program_mode=0, result <= f(opcode, A, B). Latency is 1 cycle from operand/config to tile_output.
- Opcodes (48-bit, wrap-around, two's complement where signed):
  - 0 NOP: result holds.
  - 1 ADD: A+B.
  - 2 SUB: A-B.
  - 3 MUL: low 48 bits of A*B.
  - 4 AND, 5 OR, 6 XOR: bitwise.
  - 7 NOT: ~A.
  - 8 SHL: A<<B[5:0].
  - 9 SHR: logical A>>B[5:0].
  - 10 ASR: arithmetic shift right by B[5:0].
  - 11 MIN, 12 MAX: signed.
  - 13 EQ: 1 if A==B else 0.
  - 14 LT: signed, 1 if A<B else 0.
  - 15 PASS: A.
- Shift amount boundary: a shift amount of 48-63 gives 0 for SHL/SHR. ASR gives all sign bits.
- Outputs:
  - tile_output = result.
  - send_to_tile_data slot d = route_en[d] ? result : 48'd0.
  - All outputs come directly from registers and the cfg decode, with no combinational path from recv_from_tile_data.
- Simultaneous events: the asynchronous reset overrides everything. A program_mode change takes effect at the next clock edge. Reset mid-shift discards the partial configuration.

Test Plan:
- Shift 64'h0000_0000_0000_0000 then 64'hFFFF_0000_0000_0001 (rst=1, program_mode=1, 64 clocks each) -> cfg[0] observed on jtag_data_out; the first word's bits emerge in order during the second shift.
- Program ADD, src_a=0, src_b=8, imm16=16'h0005, route_en=8'h01. Then program_mode=0, link0=48'd10 -> after 1 clk, tile_output=15, send slot0=15, slots 1-7=0.
- Program ADD, src_a=9, src_b=8, imm16=1 -> tile_output counts 1,2,3,... on successive cycles. With imm16=16'hFFFF it counts down, wrapping 0 -> 48'hFFFF_FFFF_FFFF.
- SHR, src_a=link3=48'h8000_0000_0000, src_b=imm 47 -> result 1. With imm 48 -> 0. ASR with imm 48 -> 48'hFFFF_FFFF_FFFF.
- LT signed: A=-1, B=0 -> 1. MUL: A=B=48'h1_0000_0000 -> 0 (truncated).
- Drive rst=0 mid-run and mid-shift -> all outputs 0 immediately, without waiting for a clock edge. After release, the tile needs a full 64-bit reprogram before it does anything other than output 0.
